// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the load/store path.
// One access at a time, LATENCY wait states, RISC-V sizes and faults.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [2:0]  cap_size;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          bad_size;
    logic          misalign;
    logic          bad_store;
    logic          out_range;
    logic          fault;
    logic          finish;
    logic          wr_en;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign widx      = cap_addr[AW+1:2];
    assign lane      = cap_addr[1:0];
    assign bad_size  = (cap_size == 3'b011) || (cap_size[2:1] == 2'b11);
    assign misalign  = ((cap_size[1:0] == 2'b01) && lane[0])
                     || ((cap_size[1:0] == 2'b10) && (lane != 2'b00));
    assign bad_store = cap_we && cap_size[2];
    assign out_range = |cap_addr[31:AW+2];
    assign fault     = bad_size || misalign || bad_store || out_range;
    assign finish    = (state == WAIT) && (cnt == 4'd0);
    assign wr_en     = finish && cap_we && !fault;
    assign word      = mem[widx];
    assign byte_sel  = word[{lane, 3'b000} +: 8];
    assign half_sel  = word[{lane[1], 4'b0000} +: 16];
    assign busy_o    = (state != IDLE);

    // Extract and extend the addressed lane for loads
    always_comb begin
        load_val = word;
        case (cap_size)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = word;
        endcase
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be = 4'b1111;
        wd = cap_wdata;
        case (cap_size[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{cap_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = cap_wdata;
            end
        endcase
    end

    // Store commit on the edge that enters RESP; array is never reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) begin
                mem[widx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_size  <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= 32'd0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cap_we    <= we_i;
                        cap_size  <= size_i;
                        cap_addr  <= addr_i;
                        cap_wdata <= wdata_i;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        valid_o <= 1'b1;
                        err_o   <= fault;
                        rdata_o <= (fault || cap_we) ? 32'd0 : load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 15)
// checked every cycle against a transaction-level model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [3];
    logic        we    [3];
    logic [2:0]  size  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        busy  [3];
    logic        valid [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mon_i  = -1;
    int rises[$];

    // model state
    bit          m_pend [3];
    bit          m_v    [3];
    bit          m_e    [3];
    logic [31:0] m_rd   [3];
    int          m_due  [3];
    bit          m_we   [3];
    logic [2:0]  m_sz   [3];
    logic [31:0] m_a    [3];
    logic [31:0] m_wd   [3];
    logic [7:0]  mm     [3][1024];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]),
        .size_i(size[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .busy_o(busy[0]), .valid_o(valid[0]), .rdata_o(rdata[0]),
        .err_o(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]),
        .size_i(size[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .busy_o(busy[1]), .valid_o(valid[1]), .rdata_o(rdata[1]),
        .err_o(err[1])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]),
        .size_i(size[2]), .addr_i(addr[2]), .wdata_i(wdata[2]),
        .busy_o(busy[2]), .valid_o(valid[2]), .rdata_o(rdata[2]),
        .err_o(err[2])
    );

    function automatic int lat_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            default: return 15;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_fault(input bit w, input logic [2:0] sz,
                                    input logic [31:0] a);
        int n;
        n = nbytes(sz);
        if (n == 0) return 1'b1;
        if (w && sz >= 3'b100) return 1'b1;
        if ((a % n) != 0) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input int i,
                                             input logic [2:0] sz,
                                             input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nbytes(sz);
        for (int j = 0; j < n; j++) v[8*j +: 8] = mm[i][int'(a[9:0]) + j];
        if (sz == 3'b000 && v[7])  v[31:8]  = '1;
        if (sz == 3'b001 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: accept when idle, answer LATENCY edges later
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] <= 1'b0;
                m_v[i]    <= 1'b0;
                m_e[i]    <= 1'b0;
                m_rd[i]   <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_v[i]  <= 1'b0;
                m_e[i]  <= 1'b0;
                m_rd[i] <= 32'd0;
                if (m_v[i]) begin
                end else if (!m_pend[i]) begin
                    if (req[i]) begin
                        m_pend[i] <= 1'b1;
                        m_due[i]  <= cyc + lat_of(i);
                        m_we[i]   <= we[i];
                        m_sz[i]   <= size[i];
                        m_a[i]    <= addr[i];
                        m_wd[i]   <= wdata[i];
                    end
                end else if (cyc == m_due[i]) begin
                    m_pend[i] <= 1'b0;
                    m_v[i]    <= 1'b1;
                    if (is_fault(m_we[i], m_sz[i], m_a[i])) begin
                        m_e[i] <= 1'b1;
                    end else if (m_we[i]) begin
                        for (int j = 0; j < nbytes(m_sz[i]); j++)
                            mm[i][int'(m_a[i][9:0]) + j] <= m_wd[i][8*j +: 8];
                    end else begin
                        m_rd[i] <= load_val(i, m_sz[i], m_a[i]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model
    initial begin
        bit pb [3];
        for (int i = 0; i < 3; i++) pb[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[%0d]", i), 32'(busy[i]),
                    32'(m_pend[i] || m_v[i]));
                chk($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(m_v[i]));
                chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(m_e[i]));
                chk($sformatf("rdata[%0d]", i), rdata[i], m_rd[i]);
                if (i == mon_i && busy[i] && !pb[i]) rises.push_back(cyc);
                pb[i] = busy[i];
            end
        end
    end

    task automatic access(input int i, input bit w, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input bit ee);
        int t;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; size[i] = sz; addr[i] = a; wdata[i] = wd;
        @(posedge clk);
        @(negedge clk);
        req[i] = 1'b0; we[i] = ~w; size[i] = 3'b111;
        addr[i] = 32'hFFFF_FFFF; wdata[i] = 32'h5A5A_5A5A;
        t = 1;
        while (!valid[i] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("latency[%0d]", i), 32'(t - 1), 32'(lat_of(i)));
        chk($sformatf("err@%h", a), 32'(err[i]), 32'(ee));
        chk($sformatf("model err@%h", a), 32'(m_e[i]), 32'(ee));
        if (!w) begin
            chk($sformatf("rdata@%h", a), rdata[i], er);
            chk($sformatf("model rdata@%h", a), m_rd[i], er);
        end
    endtask

    task automatic held(input int i, input int n);
        mon_i = i;
        rises.delete();
        @(negedge clk);
        req[i] = 1'b1; we[i] = 1'b0; size[i] = 3'b010;
        addr[i] = 32'h10; wdata[i] = 32'd0;
        for (int c = 0; c < 300 && rises.size() < n; c++) @(negedge clk);
        req[i] = 1'b0;
        repeat (lat_of(i) + 5) @(negedge clk);
        chk($sformatf("accept count[%0d]", i), 32'(rises.size() >= n), 32'd1);
        for (int k = 1; k < rises.size(); k++)
            chk($sformatf("accept spacing[%0d]", i),
                32'(rises[k] - rises[k-1]), 32'(lat_of(i) + 2));
        mon_i = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: test did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; size[i] = 3'd0;
            addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset busy",  32'(busy[i]),  32'd0);
            chk("reset valid", 32'(valid[i]), 32'd0);
            chk("reset err",   32'(err[i]),   32'd0);
            chk("reset rdata", rdata[i],      32'd0);
        end
        @(negedge clk); #2 rst = 1'b0;

        // word round trip
        access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 0);
        access(0, 0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 0);

        // loads with extension
        access(0, 1, 3'b010, 32'h20, 32'h80FF7F01, 32'd0, 0);
        access(0, 0, 3'b000, 32'h23, 32'd0, 32'hFFFFFF80, 0);
        access(0, 0, 3'b100, 32'h23, 32'd0, 32'h00000080, 0);
        access(0, 0, 3'b001, 32'h22, 32'd0, 32'hFFFF80FF, 0);
        access(0, 0, 3'b101, 32'h22, 32'd0, 32'h000080FF, 0);
        access(0, 0, 3'b000, 32'h20, 32'd0, 32'h00000001, 0);
        access(0, 0, 3'b000, 32'h21, 32'd0, 32'h0000007F, 0);
        access(0, 0, 3'b001, 32'h20, 32'd0, 32'h00007F01, 0);

        // partial store merge
        access(0, 1, 3'b010, 32'h30, 32'h11223344, 32'd0, 0);
        access(0, 1, 3'b000, 32'h31, 32'h123456AA, 32'd0, 0);
        access(0, 1, 3'b001, 32'h32, 32'h9999BBCC, 32'd0, 0);
        access(0, 0, 3'b010, 32'h30, 32'd0, 32'hBBCCAA44, 0);

        // faults
        access(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 32'd0, 0);
        access(0, 0, 3'b010, 32'h41, 32'd0, 32'd0, 1);
        access(0, 0, 3'b001, 32'h43, 32'd0, 32'd0, 1);
        access(0, 0, 3'b011, 32'h40, 32'd0, 32'd0, 1);
        access(0, 1, 3'b100, 32'h40, 32'h55, 32'd0, 1);
        access(0, 1, 3'b001, 32'h41, 32'hFFFF, 32'd0, 1);
        access(0, 0, 3'b010, 32'h400, 32'd0, 32'd0, 1);
        access(0, 0, 3'b010, 32'h40, 32'd0, 32'hCAFEF00D, 0);

        // reset in the middle of a store
        access(0, 1, 3'b010, 32'h50, 32'd0, 32'd0, 0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 3'b010;
        addr[0] = 32'h50; wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst busy",  32'(busy[0]),  32'd0);
        chk("rst valid", 32'(valid[0]), 32'd0);
        chk("rst err",   32'(err[0]),   32'd0);
        chk("rst rdata", rdata[0],      32'd0);
        @(negedge clk); #2 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no valid after reset", 32'(valid[0]), 32'd0);
        end
        access(0, 0, 3'b010, 32'h50, 32'd0, 32'd0, 0);

        // LATENCY = 1
        access(1, 1, 3'b010, 32'h10, 32'hA5A55A5A, 32'd0, 0);
        access(1, 0, 3'b101, 32'h12, 32'd0, 32'h0000A5A5, 0);
        access(1, 0, 3'b000, 32'h10, 32'd0, 32'h0000005A, 0);
        held(1, 4);

        // LATENCY = 15
        access(2, 1, 3'b010, 32'h10, 32'h01020304, 32'd0, 0);
        access(2, 0, 3'b100, 32'h11, 32'd0, 32'h00000003, 0);
        access(2, 0, 3'b001, 32'h12, 32'd0, 32'h00000102, 0);
        held(2, 3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the RISC-V core's load/store path. It serves one access at a time behind a request/valid handshake with a programmable number of wait states. It performs little-endian byte, halfword and word reads and writes with RISC-V sign and zero extension, and flags misaligned, out-of-range or illegal-size accesses. It sits on the memory side of the core's data port: address comes from the ALU result, write data from rs2, size from func3. The core stalls its PC while `req_i` is high and `valid_o` is low.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words in the array. Power of two, at least 4.
- `LATENCY`, default 2: wait states from acceptance to response. Legal range is 1 to 15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  access request. Sampled only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `size_i`  in  3  func3 encoding: 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, LSB-aligned.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `valid_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  32  load result. Valid only while `valid_o` = 1.
- `err_o`  out  1  access fault. Qualified by `valid_o`.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- **IDLE:** when `req_i` = 1 at a rising edge:
  - capture `we_i`, `size_i`, `addr_i`, `wdata_i`;
  - load the counter with LATENCY−1;
  - go to WAIT.
- **WAIT:**
  - If the counter is 0, go to RESP. Otherwise decrement.
  - Inputs are ignored; dropping `req_i` does not abort the access.
- **RESP:**
  - `valid_o` = 1 for exactly one cycle, then unconditionally go to IDLE.
- **Fault checks** are evaluated on the captured request:
  - H/HU with addr[0] ≠ 0;
  - W with addr[1:0] ≠ 0;
  - `size_i` ∈ {011, 110, 111};
  - store with size_i[2] = 1;
  - addr[31:2] ≥ DEPTH_WORDS.
- **On a fault:** `err_o` = 1, `rdata_o` = 0, no array write.
- **Loads:**
  - Select the byte or halfword by addr[1:0], little-endian.
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W returns the whole word.
- **Stores:**
  - Byte-enable write of wdata_i[7:0], [15:0] or [31:0] into the addressed lanes.
  - Other lanes are preserved.
- **Array:** the array is not reset, and its contents are undefined after power-up.

## Timing
- **Reset values:** `busy_o` = 0, `valid_o` = 0, `err_o` = 0, `rdata_o` = 0. State is IDLE and the counter is 0.
- **Response latency:** a request accepted at edge k gives `valid_o` high from edge k+LATENCY to edge k+LATENCY+1.
- **Store commit:** a store commits to the array at edge k+LATENCY, the same edge that raises `valid_o`.
- **Back-to-back requests:** the next request is accepted at the earliest at edge k+LATENCY+2. `req_i` during RESP is not sampled.
- **Outputs outside RESP:** `rdata_o` and `err_o` are registered and forced to 0 outside RESP.
- **Reset during WAIT or RESP:**
  - return to IDLE immediately;
  - a pending store is discarded, and the array is left untouched;
  - no `valid_o` is emitted for the aborted access.
- **`req_i` held high after the response:** it is treated as a new access on the first IDLE edge.

## Test plan
- **Word round trip, LATENCY = 2:**
  - Stimulus: SW 0xDEADBEEF @0x10, then LW @0x10.
  - Required: `valid_o` 2 edges after each acceptance, `rdata_o` = 0xDEADBEEF, `err_o` = 0.
- **Byte loads with extension:**
  - Stimulus: after SW 0x80FF7F01 @0x20, issue LB @0x23, LBU @0x23, LH @0x22, LHU @0x22, LB @0x20.
  - Required: 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x00000001.
- **Partial store merge:**
  - Stimulus: SW 0x11223344 @0x30, SB 0xAA @0x31, SH 0xBBCC @0x32, then LW @0x30.
  - Required: 0xBBCCAA44.
- **Faults:**
  - Stimulus: LW @0x41, LH @0x43, size 011 @0x40, SB-with-size-100 @0x40, LW @(DEPTH_WORDS×4).
  - Required: each gives `valid_o` = 1 with `err_o` = 1 and `rdata_o` = 0; a following LW @0x40 shows the memory unchanged.
- **Reset mid-store:**
  - Stimulus: SW 0x12345678 @0x50 over old value 0, with `rst` pulsed during WAIT.
  - Required: no `valid_o`, all outputs 0, a following LW @0x50 returns 0.
- **Handshake edge cases, LATENCY = 1 and 15:**
  - Stimulus: `req_i` dropped during WAIT, and `req_i` held continuously.
  - Required: the dropped access still completes; with `req_i` held, accepts are spaced LATENCY+2 edges apart and `busy_o` is low exactly one cycle between accesses.
